// File: rtl/fp_pkg.sv
// fp_pkg: constants and enums shared by the floating-point unit blocks.
//   FP_BIAS, FP_EXP_MAX : binary32 exponent bias and all-ones exponent
//   FP_QNAN, FP_INF     : canonical quiet NaN and +infinity encodings
//   fp_class_e          : operand class latched when an operation is accepted
//   fp_state_e          : sequencer state of the squaring unit
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_INF     = 32'h7F800000;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORMAL
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM
  } fp_state_e;

endpackage

// File: rtl/fp_square_seq_if.sv
// fp_square_seq_if: start/busy/done handshake and data of the squaring unit.
//   start  : request pulse, sampled only when the unit is not busy
//   X      : binary32 operand, captured on the accepting edge
//   busy   : operation in flight
//   done   : one-cycle pulse, result valid
//   result : registered binary32 square, held until the next done or reset
interface fp_square_seq_if;
  logic        start;
  logic [31:0] X;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, output X, input busy, input done, input result);
  modport slave  (input start, input X, output busy, output done, output result);
endinterface

// File: rtl/mant_mul24_seq.sv
// mant_mul24_seq: 24x24 radix-2 shift-add multiplier, one partial product per
// step, LSB of the multiplier first.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : clear product and counter, capture operands
//   step_i   : add one partial product and advance the counter
//   a_i, b_i : multiplicand and multiplier
//   prod_o   : 48-bit accumulated product
//   last_o   : the next step is the 24th (final) iteration
module mant_mul24_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  output logic [47:0] prod_o,
  output logic        last_o
);

  logic [23:0] mcand_q;
  logic [23:0] mplier_q;
  logic [4:0]  cnt_q;
  logic [47:0] prod_q;
  logic [47:0] pp;

  // Partial product for the current iteration: multiplicand weighted by 2^cnt.
  assign pp     = mplier_q[cnt_q] ? ({24'd0, mcand_q} << cnt_q) : 48'd0;
  assign last_o = (cnt_q == 5'd23);
  assign prod_o = prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else if (step_i) begin
      prod_q <= prod_q + pp;
      cnt_q  <= last_o ? 5'd0 : cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/fp_square_seq.sv
// fp_square_seq: sequential binary32 squaring unit, fixed 26-cycle latency.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/X in, busy/done/result out (fp_square_seq_if.slave)
// Sequencing: IDLE -> MUL (24 shift-add steps) -> NORM (normalize, round,
// apply special cases) -> IDLE with done pulsed.
module fp_square_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fp_square_seq_if.slave   bus
);

  fp_state_e   state_q, state_d;
  fp_class_e   cls_q, cls_d;
  logic [7:0]  exp_q;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        load, step, last;
  logic [47:0] prod;
  logic [23:0] mant;
  logic        sign_unused;

  // The sign is dropped: a square is never negative.
  assign sign_unused = bus.X[31];
  assign mant        = {1'b1, bus.X[22:0]};

  // Round-to-nearest-even of the 48-bit significand product with exponent
  // rebias, overflow to +inf and underflow flush to zero.
  function automatic logic [31:0] norm_round(input logic [47:0] p,
                                             input logic [7:0]  e);
    logic [23:0]       sig;
    logic              guard, sticky, rnd;
    logic [24:0]       sum;
    logic signed [9:0] ex;
    ex = $signed({1'b0, e, 1'b0}) - $signed(10'(FP_BIAS));
    if (p[47]) begin
      sig    = p[47:24];
      guard  = p[23];
      sticky = |p[22:0];
      ex     = ex + 10'sd1;
    end else begin
      sig    = p[46:23];
      guard  = p[22];
      sticky = |p[21:0];
    end
    rnd = guard & (sticky | sig[0]);
    sum = {1'b0, sig} + {24'd0, rnd};
    if (sum[24]) begin
      sig = sum[24:1];
      ex  = ex + 10'sd1;
    end else begin
      sig = sum[23:0];
    end
    if (ex >= $signed(10'(FP_EXP_MAX)))
      return FP_INF;
    else if (ex <= 10'sd0)
      return 32'h0000_0000;
    else
      return {1'b0, ex[7:0], sig[22:0]};
  endfunction

  mant_mul24_seq u_mul (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .a_i    (mant),
    .b_i    (mant),
    .prod_o (prod),
    .last_o (last)
  );

  always_comb begin
    cls_d = CLS_NORMAL;
    if (bus.X[30:23] == 8'd0)
      cls_d = CLS_ZERO;
    else if (bus.X[30:23] == 8'(FP_EXP_MAX))
      cls_d = (bus.X[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
  end

  always_comb begin
    unique case (cls_q)
      CLS_ZERO: result_d = 32'h0000_0000;
      CLS_INF:  result_d = FP_INF;
      CLS_NAN:  result_d = FP_QNAN;
      default:  result_d = norm_round(prod, exp_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) state_d = NORM;
      end
      NORM: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      exp_q    <= '0;
      cls_q    <= CLS_ZERO;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load) begin
        exp_q <= bus.X[30:23];
        cls_q <= cls_d;
      end
      if (state_q == NORM) result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fp_square_seq.sv
module tb_fp_square_seq;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fp_square_seq_if bus ();

  fp_square_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference square from the arithmetic definition: exact integer product,
  // leading-one search, round-half-even on the discarded remainder.
  function automatic logic [31:0] ref_sq(input logic [31:0] x);
    int              e, k, sh, ex;
    longint unsigned m, p, q, rem, half;
    e = int'(x[30:23]);
    if (e == 0) return 32'h0000_0000;
    if (e == 255) return (x[22:0] == 23'd0) ? 32'h7F800000 : 32'h7FC00000;
    m = 64'h80_0000 | longint'(x[22:0]);
    p = m * m;
    k = 47;
    while (p[k] == 1'b0) k--;
    sh   = k - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    ex = k - 46 + 2 * e - 127;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return 32'h7F800000;
    if (ex <= 0) return 32'h0000_0000;
    return {1'b0, ex[7:0], q[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drive a start pulse beginning at the current negedge; returns at cycle 1.
  task automatic pulse(input logic [31:0] x);
    bus.start = 1'b1;
    bus.X     = x;
    @(negedge clk);
    bus.start = 1'b0;
    bus.X     = $urandom;
  endtask

  // Called at cycle 1: waits (bounded) for done, counting latency and busy cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] expv);
    int lat, bc;
    @(negedge clk);
    pulse(x);
    wait_done(lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'd26);
    check({tag, "_busy"}, 32'(bc), 32'd25);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_res"}, bus.result, expv);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int          lat, bc, nd;
    logic [31:0] x, y;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.X     = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'h0);

    // Directed values from the arithmetic; expected values fixed by hand.
    run_op("three", 32'h40400000, 32'h41100000);
    run_op("neg_two", 32'hC0000000, 32'h40800000);
    run_op("one_half", 32'h3FC00000, 32'h40100000);
    run_op("rnd_ulp", 32'h3F800001, 32'h3F800002);
    run_op("one", 32'h3F800000, 32'h3F800000);
    run_op("nan", 32'h7FC12345, 32'h7FC00000);
    run_op("neg_inf", 32'hFF800000, 32'h7F800000);
    run_op("denorm", 32'h00000001, 32'h00000000);
    run_op("ovf", 32'h60AD78EC, 32'h7F800000);
    run_op("unf", 32'h1E3CE508, 32'h00000000);

    // Starts while busy must be ignored.
    x = 32'h40A00000;
    @(negedge clk);
    pulse(x);
    lat = 1;
    while (!bus.done && lat < 40) begin
      bus.start = (lat == 4 || lat == 19);
      bus.X     = 32'h3F800000;
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd26);
    check("ign_res", bus.result, 32'h41C80000);
    count_dones(35, nd);
    check("ign_single_done", 32'(nd), 32'd0);

    // Start in the done cycle: back-to-back operation.
    x = 32'h40400000;
    y = 32'h3FC00000;
    @(negedge clk);
    pulse(x);
    wait_done(lat, bc);
    check("b2b_first", bus.result, 32'h41100000);
    pulse(y);
    wait_done(lat, bc);
    check("b2b_lat", 32'(lat), 32'd26);
    check("b2b_res", bus.result, 32'h40100000);

    // Reset mid-operation aborts everything.
    @(negedge clk);
    pulse(32'h40400000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'h0);
    count_dones(35, nd);
    check("abort_no_done", 32'(nd), 32'd0);
    run_op("after_abort", 32'hC0000000, 32'h40800000);

    // Reset and start on the same edge: start dropped.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.X     = 32'h40400000;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    count_dones(35, nd);
    check("rst_start_no_done", 32'(nd), 32'd0);
    check("rst_start_result", bus.result, 32'h0);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      if (i % 2 == 0) x[30:23] = 8'($urandom_range(70, 185));
      run_op("rand", x, ref_sq(x));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
